// File: rtl/qracc_adc_readout.sv
// qracc_adc_readout: captures the analog macro's sense-amp and flash-ADC
// outputs after a settle delay, decodes thermometer codes to binary and
// streams the result to the digital core over a valid/ready interface.
module qracc_adc_readout #(
   parameter int unsigned NUM_COLS      = 32,
   parameter int unsigned ADC_BITS      = 4,
   parameter int unsigned COMP_COUNT    = 15,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned COLS_PER_BEAT = 8
) (
   input  logic                                clk,
   input  logic                                nrst,
   input  logic                                start_i,
   input  logic                                mode_i,
   input  logic [NUM_COLS-1:0]                 sa_out_i,
   input  logic [COMP_COUNT*NUM_COLS-1:0]      adc_out_i,
   output logic                                out_valid_o,
   input  logic                                out_ready_i,
   output logic [COLS_PER_BEAT*ADC_BITS-1:0]   out_data_o,
   output logic                                out_last_o,
   output logic                                busy_o,
   output logic                                overrun_o,
   output logic                                bubble_o,
   input  logic                                clr_err_i
);

   localparam int unsigned BEAT_W    = COLS_PER_BEAT * ADC_BITS;
   localparam int unsigned NUM_BEATS = NUM_COLS / COLS_PER_BEAT;
   localparam int unsigned BIDX_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int unsigned SCNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned DEC_W     = NUM_COLS * ADC_BITS;
   localparam int unsigned ADC_W     = COMP_COUNT * NUM_COLS;
   // SETTLE holds SETTLE_CYCLES-1 edges, the last of which enters CAPTURE
   localparam int unsigned SCNT_LOAD = (SETTLE_CYCLES >= 2) ? SETTLE_CYCLES - 2 : 0;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETTLE  = 3'd1,
      CAPTURE = 3'd2,
      DECODE  = 3'd3,
      DRAIN   = 3'd4
   } state_t;

   state_t               state_q;
   logic [SCNT_W-1:0]    settle_q;
   logic                 mode_q;
   logic [ADC_W-1:0]     cap_adc_q;
   logic [NUM_COLS-1:0]  cap_sa_q;
   logic [DEC_W-1:0]     dec_q;
   logic [BIDX_W-1:0]    beat_q;

   logic [DEC_W-1:0]      dec_c;
   logic                  bad_c;
   logic [COMP_COUNT-1:0] code_c;
   logic [BIDX_W-1:0]     beat_nxt_c;
   logic                  bub_set_c;
   logic                  ovr_set_c;

   function automatic logic [ADC_BITS-1:0] popcount(input logic [COMP_COUNT-1:0] v);
      logic [ADC_BITS-1:0] n;
      n = '0;
      for (int i = 0; i < int'(COMP_COUNT); i++) begin
         n = n + ADC_BITS'(v[i]);
      end
      return n;
   endfunction

   // Per-column popcount decode and thermometer-validity check of the capture
   always_comb begin
      dec_c  = '0;
      bad_c  = 1'b0;
      code_c = '0;
      for (int c = 0; c < int'(NUM_COLS); c++) begin
         code_c = cap_adc_q[c*COMP_COUNT +: COMP_COUNT];
         dec_c[c*ADC_BITS +: ADC_BITS] = popcount(code_c);
         // valid codes are 0..01..1, so adding one never overlaps a set bit
         if ((code_c & (code_c + COMP_COUNT'(1))) != '0) begin
            bad_c = 1'b1;
         end
      end
   end

   // Next beat index and sticky-flag set conditions
   always_comb begin
      beat_nxt_c = BIDX_W'(beat_q + 1'b1);
      bub_set_c  = (state_q == DECODE) && !mode_q && bad_c;
      ovr_set_c  = start_i && busy_o;
   end

   // Readout FSM with registered outputs and sticky error flags
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= IDLE;
         settle_q    <= '0;
         mode_q      <= 1'b0;
         cap_adc_q   <= '0;
         cap_sa_q    <= '0;
         dec_q       <= '0;
         beat_q      <= '0;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_last_o  <= 1'b0;
         busy_o      <= 1'b0;
         overrun_o   <= 1'b0;
         bubble_o    <= 1'b0;
      end else begin
         if (ovr_set_c) begin
            overrun_o <= 1'b1;
         end else if (clr_err_i) begin
            overrun_o <= 1'b0;
         end

         if (bub_set_c) begin
            bubble_o <= 1'b1;
         end else if (clr_err_i) begin
            bubble_o <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (start_i) begin
                  mode_q   <= mode_i;
                  settle_q <= SCNT_W'(SCNT_LOAD);
                  busy_o   <= 1'b1;
                  state_q  <= (SETTLE_CYCLES == 1) ? CAPTURE : SETTLE;
               end
            end
            SETTLE: begin
               if (settle_q == '0) begin
                  state_q <= CAPTURE;
               end else begin
                  settle_q <= settle_q - 1'b1;
               end
            end
            CAPTURE: begin
               cap_sa_q <= sa_out_i;
               if (!mode_q) begin
                  cap_adc_q <= adc_out_i;
               end
               state_q <= DECODE;
            end
            DECODE: begin
               dec_q       <= dec_c;
               beat_q      <= '0;
               out_valid_o <= 1'b1;
               if (mode_q) begin
                  out_data_o <= BEAT_W'(cap_sa_q);
                  out_last_o <= 1'b1;
               end else begin
                  out_data_o <= dec_c[BEAT_W-1:0];
                  out_last_o <= (NUM_BEATS == 1);
               end
               state_q <= DRAIN;
            end
            DRAIN: begin
               if (out_ready_i) begin
                  if (out_last_o) begin
                     out_valid_o <= 1'b0;
                     out_last_o  <= 1'b0;
                     out_data_o  <= '0;
                     busy_o      <= 1'b0;
                     state_q     <= IDLE;
                  end else begin
                     beat_q     <= beat_nxt_c;
                     out_data_o <= dec_q[32'(beat_nxt_c)*BEAT_W +: BEAT_W];
                     out_last_o <= (beat_nxt_c == BIDX_W'(NUM_BEATS - 1));
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
